// File: rtl/keypad_pkg.sv
// Shared key codes, debounce FSM states and small decode helpers for the keypad entry block.
package keypad_pkg;

  localparam logic [4:0] KEY_ENTER = 5'h10;
  localparam logic [4:0] KEY_BKSP  = 5'h11;
  localparam logic [4:0] KEY_CLR   = 5'h12;
  localparam logic [4:0] KEY_RSVD  = 5'h13;

  typedef enum logic [1:0] {
    IDLE,
    DEB_PRESS,
    HELD
  } key_state_t;

  // Codes 0x00-0x0F are hex digits; everything at or above 0x10 is a function key.
  function automatic logic is_digit(input logic [4:0] code);
    return code < 5'h10;
  endfunction

endpackage

// File: rtl/key_entry_if.sv
// Valid/ready output port carrying committed operands from key_entry to the core/IO bus.
interface key_entry_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/key_debounce.sv
// Strobe debouncer: accepts a press after DEBOUNCE stable high samples and re-arms only
// after DEBOUNCE consecutive low samples. accept is a single-cycle combinational pulse.
module key_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic keystrobe,
  output logic accept
);

  localparam int             CW       = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE - 1);

  key_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (keystrobe) begin
          if (DEBOUNCE == 1) begin
            accept  = 1'b1;
            state_d = HELD;
            cnt_d   = '0;
          end else begin
            state_d = DEB_PRESS;
            cnt_d   = CW'(1);
          end
        end
      end
      DEB_PRESS: begin
        if (!keystrobe) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          accept  = 1'b1;
          state_d = HELD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      HELD: begin
        // In HELD the counter tracks consecutive low samples; any high sample restarts it.
        if (keystrobe) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: rtl/key_entry.sv
// Keypad operand entry: debounced key actions edit a hex entry register and ENTER commits
// it to a valid/ready output port.
module key_entry
  import keypad_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int DEBOUNCE = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [4:0]                    keycode,
  input  logic                          keystrobe,
  output logic [WIDTH-1:0]              entry,
  output logic [$clog2(WIDTH/4+1)-1:0]  ndigits,
  output logic                          key_event,
  output logic                          err,
  key_entry_if.master                   out_if
);

  localparam int MAXDIG = WIDTH / 4;
  localparam int NDW    = $clog2(MAXDIG + 1);

  logic             accept;
  logic [WIDTH-1:0] entry_q, entry_d;
  logic [NDW-1:0]   ndigits_q, ndigits_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             key_event_q, key_event_d;
  logic             err_q, err_d;

  key_debounce #(.DEBOUNCE(DEBOUNCE)) u_debounce (
    .clk       (clk),
    .rst       (rst),
    .keystrobe (keystrobe),
    .accept    (accept)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      entry_q     <= '0;
      ndigits_q   <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      key_event_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      entry_q     <= entry_d;
      ndigits_q   <= ndigits_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      key_event_q <= key_event_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    entry_d     = entry_q;
    ndigits_d   = ndigits_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    key_event_d = accept;
    err_d       = 1'b0;

    // Consumer handshake; a same-edge ENTER commit below overrides this clear.
    if (out_valid_q && out_if.out_ready) out_valid_d = 1'b0;

    if (accept) begin
      if (is_digit(keycode)) begin
        if (ndigits_q < NDW'(MAXDIG)) begin
          entry_d   = {entry_q[WIDTH-5:0], keycode[3:0]};
          ndigits_d = ndigits_q + NDW'(1);
        end else begin
          err_d = 1'b1;
        end
      end else begin
        case (keycode)
          KEY_ENTER: begin
            // out_data may only move when nothing is pending or the pending word leaves now.
            if (!out_valid_q || out_if.out_ready) begin
              out_data_d  = entry_q;
              out_valid_d = 1'b1;
              entry_d     = '0;
              ndigits_d   = '0;
            end else begin
              err_d = 1'b1;
            end
          end
          KEY_BKSP: begin
            if (ndigits_q != '0) begin
              entry_d   = entry_q >> 4;
              ndigits_d = ndigits_q - NDW'(1);
            end
          end
          KEY_CLR: begin
            entry_d   = '0;
            ndigits_d = '0;
          end
          default: ;  // KEY_RSVD and unused codes only pulse key_event
        endcase
      end
    end
  end

  assign entry            = entry_q;
  assign ndigits          = ndigits_q;
  assign key_event        = key_event_q;
  assign err              = err_q;
  assign out_if.out_data  = out_data_q;
  assign out_if.out_valid = out_valid_q;

endmodule
